reg_write_arbiter: RTL
======================

# reg_write_arbiter

Round-robin write arbiter and controller for a shared 16-bit register. Up to N requesters compete for write access. The block grants one requester at a time, drives the register's `in`/`load` from the winner, and returns a one-cycle `ack` once the value is stored. It sits between multiple producers (CPU write path, I/O loaders) and a single architectural register.

## Interface
- `N`, 4, number of requesters (2..8)
- `WIDTH`, 16, data width
- `clk`  input  1  rising-edge clock
- `reset`  input  1  asynchronous, active-high reset
- `req`  input  N  per-requester write request; held until matching `ack`
- `wdata`  input  N×WIDTH (packed `[N-1:0][WIDTH-1:0]`)  per-requester write data
- `gnt`  output  N  one-hot grant, registered
- `ack`  output  N  one-hot, one-cycle write-done pulse, registered
- `out`  output  WIDTH  current register contents
- `owner`  output  $clog2(N)  index of last successful writer
- `valid`  output  1  high once any write has completed since reset

## Operation
- FSM states: IDLE, GRANT, ACK.
- **IDLE**
  - If `req` is 0, stay in IDLE.
  - Otherwise pick winner `w`: the first set `req` bit searching upward from `ptr`, wrapping N-1→0.
  - At the clock edge: go to GRANT, set `gnt[w]=1`, latch `sel=w`, set `ptr=(w+1) mod N`.
- **GRANT**
  - Internal store load is active with data `wdata[sel]`.
  - At the clock edge: `out` takes `wdata[sel]`, `owner` takes `sel`, `valid` becomes 1, `gnt` clears, `ack[sel]` becomes 1, state goes to ACK.
- **ACK**
  - `req` is ignored during this cycle.
  - At the clock edge: `ack` clears, state goes to IDLE.
- Requester rules:
  - Hold `req` and `wdata` stable from assertion through the GRANT cycle.
  - Drop `req` by the edge ending the ACK cycle. If `req` is still high in the following IDLE cycle, it counts as a new request.
- If `req[sel]` drops during GRANT, the write still completes with the `wdata[sel]` sampled at the GRANT edge, and `ack` still pulses. There is no abort.
- `out` changes only at the edge that ends a GRANT cycle. In every other state `out` holds its value.
- Width rules:
  - `ptr` and `sel` are $clog2(N) bits.
  - The wrap for non-power-of-2 N is an explicit compare against N-1, not natural overflow.
- Reset, asynchronous at any time including mid-GRANT or mid-ACK:
  - state=IDLE, `ptr`=0, `sel`=0, `gnt`=0, `ack`=0, `out`=0, `owner`=0, `valid`=0.
  - An in-flight write is lost; no `ack` is issued for it.

## Timing
- Arbitration happens in an IDLE cycle with `req`≠0.
- Cycle +1: `gnt` is high.
- Cycle +2: `out` has the new value and `ack` is high.
- Cycle +3: back in IDLE; earliest next grant is visible at +4.
- Throughput: one write per 3 cycles.
- Fairness: with all `req` held high, grants rotate 0,1,…,N-1,0; a continuously requesting port waits at most N-1 writes.
- Outputs are pure flops: no combinational path from `req` or `wdata` to any output.
- `gnt` and `ack` are never high in the same cycle, and each has at most one bit set.

## Structure
- Package `reg_arb_pkg`:
  - `state_t` enum {IDLE, GRANT, ACK};
  - default `N`/`WIDTH` localparams;
  - `IDX_W = $clog2(N)` helper function.
- Sub-module `rr_pick`: combinational `(req, ptr) → (any, idx)` priority search with wrap. It is reused by later arbiters.
- Storage: a WIDTH-bit flop with async reset inside `reg_write_arbiter`, loaded only in GRANT.

## Test plan
- **Reset:** assert `reset` mid-GRANT with `wdata[0]`=12345 → `gnt`, `ack`, `out`, `owner`, `valid` all 0 immediately; after release, `out` stays 0 with `req`=0.
- **Single write:** `req[2]=1`, `wdata[2]`=-32123 (16'h8285) in IDLE → next cycle `gnt`=4'b0100; cycle after, `out`=16'h8285, `ack`=4'b0100, `owner`=2, `valid`=1.
- **Hold:** after that write, `req`=0 for 5 cycles with `wdata` changing to 11111 → `out` stays 16'h8285, no `gnt`/`ack`.
- **Round-robin:** all four `req` held high, `wdata[i]`=i+1 → grant order 0,1,2,3,0; `out` sequence 1,2,3,4,1, one new value every 3 cycles.
- **Wrap/priority:** after a grant to port 3, assert `req`=4'b0011 → port 0 wins first, then port 1.
- **Early drop:** `req[1]` drops during GRANT with `wdata[1]`=12345 → `out`=12345 and `ack[1]` still pulses; keeping `req[1]` high through the next IDLE cycle produces a second grant.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared types, defaults and index-width helper for the register write arbiter
package reg_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;
  localparam int DEF_N = 4;
  localparam int DEF_WIDTH = 16;
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin priority search, first set req bit at or above ptr with wrap to 0
module rr_pick #(
  parameter int N = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);
  // Scan offsets from farthest to nearest so the nearest set bit wins last
  always_comb begin
    any = |req;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      logic [IW:0] c;
      c = {1'b0, ptr} + (IW+1)'(k);
      if (c >= (IW+1)'(N)) c = c - (IW+1)'(N);
      if (req[c]) idx = c[IW-1:0];
    end
  end
endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin write arbiter in front of a single shared register
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int WIDTH = DEF_WIDTH,
  localparam int IW = idx_w(N)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N-1:0]              req,
  input  logic [N-1:0][WIDTH-1:0]   wdata,
  output logic [N-1:0]              gnt,
  output logic [N-1:0]              ack,
  output logic [WIDTH-1:0]          out,
  output logic [IW-1:0]             owner,
  output logic                      valid
);
  state_t state, state_n;
  logic [IW-1:0] ptr, sel, pick;
  logic any;
  rr_pick #(.N(N), .IW(IW)) u_pick (.req(req), .ptr(ptr), .any(any), .idx(pick));
  // Next state: arbitrate in IDLE, write in GRANT, acknowledge in ACK
  always_comb begin
    state_n = (state == IDLE) ? (any ? GRANT : IDLE) : (state == GRANT) ? ACK : IDLE;
  end
  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  // Grant/ack pulses, winner latch and rotating pointer with explicit wrap at N-1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt <= '0;
      ack <= '0;
      sel <= '0;
      ptr <= '0;
    end else begin
      gnt <= '0;
      ack <= '0;
      if (state == IDLE && any) begin
        gnt <= N'(1) << pick;
        sel <= pick;
        ptr <= (pick == IW'(N - 1)) ? '0 : pick + 1'b1;
      end
      if (state == GRANT) ack <= N'(1) << sel;
    end
  end
  // Shared register: loaded from the winner only at the end of GRANT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out   <= '0;
      owner <= '0;
      valid <= 1'b0;
    end else if (state == GRANT) begin
      out   <= wdata[sel];
      owner <= sel;
      valid <= 1'b1;
    end
  end
endmodule
